nest_stream_fifo: RTL

//  Elastic buffer between a producer interface and a consumer reached through a nested interface port.

---
 rtl/nest_stream_pkg.sv | 20 ++
 rtl/nest_stream_fifo_mem.sv | 27 ++
 rtl/nest_stream_fifo.sv | 138 +++++++++++++
 3 files changed

// File: rtl/nest_stream_pkg.sv
// Shared types and constants for the nested-port stream FIFO.
// Optional statistics are enabled by defining NEST_STREAM_FIFO_STATS_EN.
package nest_stream_pkg;

  // Default payload width used by the beat_t convenience type
  localparam int BEAT_W_DEF = 8;

  // Width of the saturating stall counter exported with the statistics
  localparam int STALL_CNT_W = 16;

  typedef logic [BEAT_W_DEF-1:0] beat_t;

  // Coarse occupancy classification, used by the sanity assertions
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } fifo_state_e;

endpackage : nest_stream_pkg

// File: rtl/nest_stream_fifo_mem.sv
// Storage array for the stream FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately never reset.
module nest_stream_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wrEn,
  input  logic [AW-1:0]     i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [AW-1:0]     i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Capture the incoming beat at the write pointer when a push is accepted
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule : nest_stream_fifo_mem

// File: rtl/nest_stream_fifo.sv
// Elastic valid/ready FIFO between a producer and a nested-port consumer.
// Holds the read/write pointers, the occupancy level and the handshake logic.
// Defining NEST_STREAM_FIFO_STATS_EN adds the stall_cnt and peak_level ports.
module nest_stream_fifo
  import nest_stream_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  level
`ifdef NEST_STREAM_FIFO_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]       peak_level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [CNT_W-1:0]  r_level;
  logic              r_outOfReset;
  logic [CNT_W-1:0]  w_levelNext;
  logic              w_push;
  logic              w_pop;
  logic              w_outValid;
  logic [DATA_W-1:0] w_rdData;
  fifo_state_e       w_state;

  nest_stream_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk      (clk),
    .i_wrEn   (w_push),
    .i_wrAddr (r_wrPtr),
    .i_wrData (in_data),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_rdData)
  );

  // Handshakes depend only on registered state, so no input-to-output paths
  assign in_ready   = r_outOfReset & (r_level != FULL_LVL);
  assign w_outValid = (r_level != '0);
  assign out_valid  = w_outValid;
  assign out_data   = w_outValid ? w_rdData : '0;
  assign level      = r_level;
  assign w_push     = in_valid & in_ready;
  assign w_pop      = w_outValid & out_ready;

  // Next occupancy: push and pop on the same edge cancel out
  always_comb begin
    w_levelNext = r_level;
    case ({w_push, w_pop})
      2'b10:   w_levelNext = r_level + CNT_W'(1);
      2'b01:   w_levelNext = r_level - CNT_W'(1);
      default: w_levelNext = r_level;
    endcase
  end

  // Pointers wrap naturally at DEPTH; in_ready opens on the first edge out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_level      <= '0;
      r_outOfReset <= 1'b0;
    end else begin
      r_outOfReset <= 1'b1;
      r_level      <= w_levelNext;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
    end
  end

  // Classify occupancy for the consistency checks below
  always_comb begin
    w_state = ST_PARTIAL;
    if (r_level == '0) begin
      w_state = ST_EMPTY;
    end else if (r_level == FULL_LVL) begin
      w_state = ST_FULL;
    end
  end

`ifdef NEST_STREAM_FIFO_STATS_EN
  logic [STALL_CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0]       r_peakLevel;

  // Count back-pressured cycles (saturating) and track the highest occupancy seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt  <= '0;
      r_peakLevel <= '0;
    end else begin
      if (w_outValid && !out_ready && (r_stallCnt != '1)) begin
        r_stallCnt <= r_stallCnt + STALL_CNT_W'(1);
      end
      if (w_levelNext > r_peakLevel) begin
        r_peakLevel <= w_levelNext;
      end
    end
  end

  assign stall_cnt  = r_stallCnt;
  assign peak_level = r_peakLevel;
`endif

`ifndef SYNTHESIS
  // Occupancy can never exceed the storage size
  a_levelBound: assert property (@(posedge clk) disable iff (!rst_n)
    r_level <= FULL_LVL);

  // A full FIFO must never accept a beat
  a_noPushFull: assert property (@(posedge clk) disable iff (!rst_n)
    (w_state == ST_FULL) |-> !w_push);

  // An empty FIFO must never present a beat
  a_noPopEmpty: assert property (@(posedge clk) disable iff (!rst_n)
    (w_state == ST_EMPTY) |-> !w_pop);
`endif

endmodule : nest_stream_fifo
